// File: rtl/lsd_segment_buffer_pkg.sv
// ============================================================================
// lsd_segment_buffer_pkg : shared types and field helpers for the segment buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsd_segment_buffer_pkg;

  localparam int ANGLE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Packed word layout is {start_v, start_h, end_v, end_h, angle}, MSB first.
  function automatic int seg_width(input int v_w, input int h_w);
    return 2 * v_w + 2 * h_w + ANGLE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsd_seg_ram.sv
// ============================================================================
// lsd_seg_ram : simple dual-port RAM, one write port, one registered read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsd_seg_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 48,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // No reset on the array or read register so the tools can map it to a BRAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/lsd_segment_buffer.sv
// ============================================================================
// lsd_segment_buffer : ping-pong collector of per-frame LSD segments with an
//                      indexed request/ack read port on the committed list
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsd_segment_buffer
  import lsd_segment_buffer_pkg::*;
#(
  parameter int FRAME_HEIGHT = 700,
  parameter int FRAME_WIDTH  = 1000,
  parameter int MAX_SEGMENTS = 256,
  localparam int V_W   = $clog2(FRAME_HEIGHT),
  localparam int H_W   = $clog2(FRAME_WIDTH),
  localparam int IDX_W = $clog2(MAX_SEGMENTS)
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               in_flag,
  input  logic               in_valid,
  input  logic [V_W-1:0]     in_start_v,
  input  logic [V_W-1:0]     in_end_v,
  input  logic [H_W-1:0]     in_start_h,
  input  logic [H_W-1:0]     in_end_h,
  input  logic [ANGLE_W-1:0] in_angle,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_ack,
  output logic               rd_hit,
  output logic [V_W-1:0]     rd_start_v,
  output logic [H_W-1:0]     rd_start_h,
  output logic [V_W-1:0]     rd_end_v,
  output logic [H_W-1:0]     rd_end_h,
  output logic [ANGLE_W-1:0] rd_angle,
  output logic [IDX_W:0]     out_count,
  output logic               out_overflow,
  output logic               out_frame_done
);

  localparam int             SEG_W   = seg_width(V_W, H_W);
  localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_SEGMENTS);

  state_e           state_q, state_d;
  logic             wbank_q, wbank_d;
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;
  logic             rd_ack_q;
  logic             rd_hit_q, rd_hit_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [SEG_W-1:0] wr_word;
  logic [SEG_W-1:0] rd_word;

  always_comb begin
    state_d      = state_q;
    wbank_d      = wbank_q;
    wr_ptr_d     = wr_ptr_q;
    ovf_acc_d    = ovf_acc_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = wr_ptr_q[IDX_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (in_flag) begin
          state_d   = ST_COLLECT;
          ovf_acc_d = 1'b0;
          wr_idx    = '0;
          wr_ptr_d  = '0;
          if (in_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = (IDX_W + 1)'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (!in_flag) begin
          state_d      = ST_IDLE;
          wbank_d      = ~wbank_q;
          count_d      = wr_ptr_q;
          overflow_d   = ovf_acc_q;
          frame_done_d = 1'b1;
        end else if (in_valid) begin
          if (wr_ptr_q < MAX_CNT) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            ovf_acc_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wbank_q      <= 1'b0;
      wr_ptr_q     <= '0;
      ovf_acc_q    <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      wr_ptr_q     <= wr_ptr_d;
      ovf_acc_q    <= ovf_acc_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Hit is decided against the count live at the request cycle, matching the RAM bank read then.
  assign rd_hit_d = ({1'b0, rd_index} < count_q);

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ack_q <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_ack_q <= rd_req;
      if (rd_req) begin
        rd_hit_q <= rd_hit_d;
      end
    end
  end

  assign wr_word = {in_start_v, in_start_h, in_end_v, in_end_h, in_angle};

  lsd_seg_ram #(
    .DEPTH (2 * MAX_SEGMENTS),
    .WIDTH (SEG_W)
  ) u_ram (
    .clk       (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i ({wbank_q, wr_idx}),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_req),
    .rd_addr_i ({~wbank_q, rd_index}),
    .rd_data_o (rd_word)
  );

  // A miss (or the post-reset state) presents zero data regardless of RAM contents.
  assign rd_start_v = rd_hit_q ? rd_word[SEG_W-1 -: V_W]                   : '0;
  assign rd_start_h = rd_hit_q ? rd_word[SEG_W-V_W-1 -: H_W]               : '0;
  assign rd_end_v   = rd_hit_q ? rd_word[SEG_W-V_W-H_W-1 -: V_W]           : '0;
  assign rd_end_h   = rd_hit_q ? rd_word[ANGLE_W+H_W-1 -: H_W]             : '0;
  assign rd_angle   = rd_hit_q ? rd_word[ANGLE_W-1:0]                      : '0;

  assign rd_ack         = rd_ack_q;
  assign rd_hit         = rd_hit_q;
  assign out_count      = count_q;
  assign out_overflow   = overflow_q;
  assign out_frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lsd_segment_buffer.sv
// ============================================================================
// tb_lsd_segment_buffer : table- and scoreboard-checked bench for the buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsd_segment_buffer;

  typedef struct packed {
    logic [9:0] sv;
    logic [9:0] sh;
    logic [9:0] ev;
    logic [9:0] eh;
    logic [7:0] ang;
  } seg_t;

  typedef struct {
    logic hit;
    seg_t seg;
  } exp_t;

  typedef struct {
    int   idx;
    logic hit;
    seg_t seg;
  } vec_t;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       in_flag = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_start_v = '0, in_end_v = '0, in_start_h = '0, in_end_h = '0;
  logic [7:0] in_angle = '0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_index = '0;
  logic       rd_ack, rd_hit;
  logic [9:0] rd_start_v, rd_start_h, rd_end_v, rd_end_h;
  logic [7:0] rd_angle;
  logic [8:0] out_count;
  logic       out_overflow, out_frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb_q[$];
  seg_t committed[$];
  seg_t pend[$];
  bit   m_active  = 0;
  bit   m_pend_ovf = 0;
  bit   m_ovf     = 0;

  lsd_segment_buffer dut (
    .clock          (clock),
    .rst            (rst),
    .in_flag        (in_flag),
    .in_valid       (in_valid),
    .in_start_v     (in_start_v),
    .in_end_v       (in_end_v),
    .in_start_h     (in_start_h),
    .in_end_h       (in_end_h),
    .in_angle       (in_angle),
    .rd_req         (rd_req),
    .rd_index       (rd_index),
    .rd_ack         (rd_ack),
    .rd_hit         (rd_hit),
    .rd_start_v     (rd_start_v),
    .rd_start_h     (rd_start_h),
    .rd_end_v       (rd_end_v),
    .rd_end_h       (rd_end_h),
    .rd_angle       (rd_angle),
    .out_count      (out_count),
    .out_overflow   (out_overflow),
    .out_frame_done (out_frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic seg_t mk(input int sv, input int sh, input int ev, input int eh, input int ang);
    seg_t s;
    s.sv = 10'(sv); s.sh = 10'(sh); s.ev = 10'(ev); s.eh = 10'(eh); s.ang = 8'(ang);
    return s;
  endfunction

  function automatic seg_t gen(input int i);
    return mk(i % 700, (i * 7) % 1000, (i * 3 + 5) % 700, (i * 11 + 1) % 1000, i * 13);
  endfunction

  function automatic exp_t model_read(input int idx);
    exp_t e;
    e.hit = (idx < committed.size());
    e.seg = e.hit ? committed[idx] : '0;
    return e;
  endfunction

  // Scoreboard consumer: every ack pops the expectation pushed at its request.
  always @(negedge clock) begin
    if (!rst && rd_ack) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack actual=1 expected=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rd_data", 64'({rd_hit, rd_start_v, rd_start_h, rd_end_v, rd_end_h, rd_angle}),
            64'({e.hit, e.seg}));
      end
    end
  end

  task automatic step(input bit flag, input bit valid, input seg_t seg,
                      input bit req, input int idx, input exp_t e);
    bit commit;
    in_flag    = flag;
    in_valid   = valid;
    in_start_v = seg.sv; in_start_h = seg.sh;
    in_end_v   = seg.ev; in_end_h   = seg.eh;
    in_angle   = seg.ang;
    rd_req     = req;
    rd_index   = 8'(idx);
    if (req) sb_q.push_back(e);
    @(posedge clock);
    commit = 0;
    if (flag) begin
      if (!m_active) begin
        m_active = 1; pend.delete(); m_pend_ovf = 0;
      end
      if (valid) begin
        if (pend.size() < 256) pend.push_back(seg);
        else m_pend_ovf = 1;
      end
    end else if (m_active) begin
      m_active = 0; committed = pend; m_ovf = m_pend_ovf; commit = 1;
    end
    #1;
    chk("rd_ack", 64'(rd_ack), 64'(req));
    chk("frame_done", 64'(out_frame_done), 64'(commit));
    chk("out_count", 64'(out_count), 64'(committed.size()));
    chk("out_overflow", 64'(out_overflow), 64'(m_ovf));
  endtask

  task automatic idle(input int n);
    exp_t z;
    z = '{hit: 1'b0, seg: '0};
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, z);
  endtask

  task automatic rd(input int idx);
    step(0, 0, '0, 1, idx, model_read(idx));
  endtask

  task automatic wr(input seg_t s);
    exp_t z;
    z = '{hit: 1'b0, seg: '0};
    step(1, 1, s, 0, 0, z);
  endtask

  task automatic do_reset();
    rst = 1; in_flag = 0; in_valid = 0; rd_req = 0;
    @(posedge clock);
    #1;
    rst = 0;
    sb_q.delete(); committed.delete(); pend.delete();
    m_active = 0; m_pend_ovf = 0; m_ovf = 0;
    chk("rst_ack", 64'(rd_ack), 0);
    chk("rst_hit", 64'(rd_hit), 0);
    chk("rst_data", 64'({rd_start_v, rd_start_h, rd_end_v, rd_end_h, rd_angle}), 0);
    chk("rst_count", 64'(out_count), 0);
    chk("rst_ovf", 64'(out_overflow), 0);
    chk("rst_done", 64'(out_frame_done), 0);
  endtask

  initial begin
    vec_t rtab[6];
    exp_t z;
    z = '{hit: 1'b0, seg: '0};
    rtab[0] = '{idx: 0,   hit: 1'b1, seg: mk(10, 20, 100, 200, 45)};
    rtab[1] = '{idx: 1,   hit: 1'b1, seg: mk(0, 999, 699, 0, 255)};
    rtab[2] = '{idx: 2,   hit: 1'b1, seg: mk(345, 512, 346, 513, 0)};
    rtab[3] = '{idx: 3,   hit: 1'b0, seg: '0};
    rtab[4] = '{idx: 255, hit: 1'b0, seg: '0};
    rtab[5] = '{idx: 0,   hit: 1'b1, seg: mk(10, 20, 100, 200, 45)};

    do_reset();
    rd(0);
    rd(7);
    idle(2);

    // Three-segment frame, then table-driven reads issued back to back.
    step(1, 0, '0, 0, 0, z);
    for (int i = 0; i < 3; i++) wr(rtab[i].seg);
    idle(1);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1, rtab[i].idx, '{hit: rtab[i].hit, seg: rtab[i].seg});
    idle(2);

    // 300 segments overflow a 256-entry bank.
    for (int i = 0; i < 300; i++) wr(gen(i));
    idle(1);
    rd(255);
    rd(0);
    rd(128);
    idle(2);

    // Next frame collected while the overflowed list is read every cycle, commit cycle included.
    for (int i = 0; i < 4; i++) step(1, 1, gen(1000 + i), 1, (i * 61) % 256, model_read((i * 61) % 256));
    step(1, 0, '0, 1, 255, model_read(255));
    step(0, 0, '0, 1, 254, model_read(254));
    for (int i = 0; i < 5; i++) rd(i);
    idle(2);

    // Valid without flag is ignored; an empty window commits count 0.
    for (int i = 0; i < 3; i++) step(0, 1, gen(50 + i), 0, 0, z);
    for (int i = 0; i < 3; i++) step(1, 0, gen(60 + i), 0, 0, z);
    idle(1);
    rd(0);
    idle(2);

    // Reset in the middle of a window discards it.
    for (int i = 0; i < 5; i++) wr(gen(200 + i));
    do_reset();
    rd(0);
    wr(mk(1, 2, 3, 4, 5));
    wr(mk(699, 999, 698, 998, 200));
    idle(1);
    rd(0);
    rd(1);
    rd(2);
    idle(3);

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
